// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the fetch/data memory port arbiter and its byte sequencer.
package mem_port_arbiter_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [0:0] ARB_IDLE = 1'b0;
    localparam logic [0:0] ARB_BUSY = 1'b1;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_DM = 1'b1;

    typedef struct packed {
        logic       owner;
        logic       we;
        logic [1:0] last_idx;
    } grant_t;

    // Index of the final beat; the reserved size code is handled as a word.
    function automatic logic [1:0] last_beat_idx(input logic [1:0] size);
        case (size)
            SIZE_BYTE: last_beat_idx = 2'd0;
            SIZE_HALF: last_beat_idx = 2'd1;
            default:   last_beat_idx = 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_sequencer.sv
// Beat counter, wrapping byte address and little-endian lane capture/select
// for one word/half/byte transfer on the byte-wide memory port.
module mem_byte_sequencer
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [1:0]        start_last,
    input  logic              start_we,
    input  logic [31:0]       start_wdata,
    input  logic              active,
    input  logic [7:0]        mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    output logic              last_beat,
    output logic [31:0]       assembled
);

    logic [ADDR_W-1:0] base;
    logic [1:0]        beat;
    logic [1:0]        last_idx;
    logic              we;
    logic [31:0]       wdata;
    logic [31:0]       asm_q;
    logic [31:0]       asm_next;

    // The current beat's byte is merged here so the final beat can publish in the same edge.
    always_comb begin
        asm_next = asm_q;
        if (!we) begin
            asm_next[{beat, 3'b000} +: 8] = mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            base     <= '0;
            beat     <= 2'd0;
            last_idx <= 2'd0;
            we       <= 1'b0;
            wdata    <= 32'h0;
            asm_q    <= 32'h0;
        end else if (start) begin
            base     <= start_addr;
            beat     <= 2'd0;
            last_idx <= start_last;
            we       <= start_we;
            wdata    <= start_wdata;
            asm_q    <= 32'h0;
        end else if (active) begin
            beat     <= beat + 2'd1;
            asm_q    <= asm_next;
        end
    end

    assign mem_addr  = active ? base + ADDR_W'(beat) : '0;
    assign mem_we    = active && we;
    assign mem_wdata = (active && we) ? wdata[{beat, 3'b000} +: 8] : 8'h00;
    assign last_beat = active && (beat == last_idx);
    assign assembled = asm_next;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the byte-wide memory port between instruction fetch and data load/store,
// serialising each access into little-endian byte beats.
//
// state    | meaning
// ARB_IDLE | arbitrate; data side wins unless its done is high this cycle
// ARB_BUSY | one byte beat per cycle until the last beat of the owner's access
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_SIZE = 1024,
    parameter int ADDR_W   = $clog2(MEM_SIZE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_done,
    output logic [31:0]       if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [1:0]        dm_size,
    input  logic [31:0]       dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic              dm_done,
    output logic [31:0]       dm_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    logic [0:0]        state;
    logic              owner;
    logic              dm_grant;
    logic              if_grant;
    logic              start;
    grant_t            grant;
    logic [ADDR_W-1:0] start_addr;
    logic [31:0]       start_wdata;
    logic              last_beat;
    logic [31:0]       assembled;
    logic              unused_addr_bits;

    // Masking a requester on its done cycle hands the next slot to the other side.
    always_comb begin
        dm_grant = (state == ARB_IDLE) && dm_req && !dm_done;
        if_grant = (state == ARB_IDLE) && if_req && !if_done && !dm_grant;
        start    = dm_grant || if_grant;
        grant    = '{owner: OWNER_IF, we: 1'b0, last_idx: last_beat_idx(SIZE_WORD)};
        start_addr  = if_addr[ADDR_W-1:0];
        start_wdata = 32'h0;
        if (dm_grant) begin
            grant       = '{owner: OWNER_DM, we: dm_we, last_idx: last_beat_idx(dm_size)};
            start_addr  = dm_addr[ADDR_W-1:0];
            start_wdata = dm_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ARB_IDLE;
            owner    <= OWNER_IF;
            if_done  <= 1'b0;
            dm_done  <= 1'b0;
            if_rdata <= 32'h0;
            dm_rdata <= 32'h0;
        end else begin
            if_done <= 1'b0;
            dm_done <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (start) begin
                        state <= ARB_BUSY;
                        owner <= grant.owner;
                    end
                end
                default: begin
                    if (last_beat) begin
                        state <= ARB_IDLE;
                        if (owner == OWNER_DM) begin
                            dm_done  <= 1'b1;
                            dm_rdata <= assembled;
                        end else begin
                            if_done  <= 1'b1;
                            if_rdata <= assembled;
                        end
                    end
                end
            endcase
        end
    end

    assign busy = (state == ARB_BUSY);

    mem_byte_sequencer #(.ADDR_W(ADDR_W)) u_seq (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .start_addr  (start_addr),
        .start_last  (grant.last_idx),
        .start_we    (grant.we),
        .start_wdata (start_wdata),
        .active      (busy),
        .mem_rdata   (mem_rdata),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .last_beat   (last_beat),
        .assembled   (assembled)
    );

    assign unused_addr_bits = ^{if_addr[31:ADDR_W], dm_addr[31:ADDR_W]};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a byte-wide behavioural memory.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int MEM_SIZE = 1024;
    localparam int ADDR_W   = 10;

    typedef struct packed {
        logic        is_dm;
        logic [31:0] data;
        logic [31:0] cyc;
    } exp_t;

    logic              clk;
    logic              reset;
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_done;
    logic [31:0]       if_rdata;
    logic              dm_req;
    logic              dm_we;
    logic [1:0]        dm_size;
    logic [31:0]       dm_addr;
    logic [31:0]       dm_wdata;
    logic              dm_done;
    logic [31:0]       dm_rdata;
    logic              busy;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    exp_t              exp_q[$];
    logic [ADDR_W-1:0] alog[$];
    logic [ADDR_W+7:0] wlog[$];
    int vectors    = 0;
    int miscompares = 0;

    logic [7:0]        mem [0:MEM_SIZE-1];
    logic              poke_en;
    logic [ADDR_W-1:0] poke_addr;
    logic [7:0]        poke_data;

    mem_port_arbiter #(.MEM_SIZE(MEM_SIZE), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_done(dm_done), .dm_rdata(dm_rdata),
        .busy(busy), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        else if (poke_en) mem[poke_addr] <= poke_data;
    end
    assign mem_rdata = mem[mem_addr];

    always @(negedge clk) begin
        if (busy) alog.push_back(mem_addr);
        if (mem_we) wlog.push_back({mem_addr, mem_wdata});
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic poke(input int a, input logic [7:0] d);
        poke_en = 1'b1; poke_addr = a[ADDR_W-1:0]; poke_data = d;
        step();
        poke_en = 1'b0;
    endtask

    // Drives one data request, scrambles the inputs once BUSY, and reports when dm_done appears.
    task automatic dm_xfer(input logic we, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, output int lat, output logic [31:0] rdata,
                           output bit got);
        dm_req = 1'b1; dm_we = we; dm_size = size; dm_addr = addr; dm_wdata = wdata;
        got = 0; lat = -1; rdata = 32'h0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (dm_done) begin got = 1; lat = n; rdata = dm_rdata; end
            if (n == 1) begin dm_addr = ~addr; dm_wdata = ~wdata; dm_size = ~size; dm_we = ~we; end
        end
        step();
        dm_req = 1'b0;
    endtask

    task automatic if_xfer(input logic [31:0] addr, output int lat, output logic [31:0] rdata,
                           output bit got);
        if_req = 1'b1; if_addr = addr;
        got = 0; lat = -1; rdata = 32'h0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (if_done) begin got = 1; lat = n; rdata = if_rdata; end
            if (n == 1) if_addr = ~addr;
        end
        step();
        if_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        @(negedge clk);
        vectors++;
        if ({if_done, dm_done, if_rdata, dm_rdata, busy, mem_we, mem_addr, mem_wdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %0h expected 0",
                     {if_done, dm_done, if_rdata, dm_rdata, busy, mem_we, mem_addr, mem_wdata});
        end
        step();
        reset = 1'b0;
        step();
        @(negedge clk);
        vectors++;
        if ({busy, mem_we, if_done, dm_done} !== 4'b0000) begin
            miscompares++;
            $display("FAIL idle_after_reset: got %b expected 0000", {busy, mem_we, if_done, dm_done});
        end
        step();
    endtask

    task automatic test_fetch();
        int lat; logic [31:0] data; bit got; exp_t e;
        logic [7:0] img [0:7] = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        for (int i = 0; i < 8; i++) poke(i, img[i]);
        wlog.delete();
        exp_q.push_back('{is_dm: 1'b0, data: 32'h0010_0593, cyc: 32'd5});
        if_xfer(32'h4, lat, data, got);
        e = exp_q.pop_front();
        vectors++;
        if (!got || data !== e.data) begin
            miscompares++;
            $display("FAIL fetch_data: got %h (done=%0d) expected %h", data, got, e.data);
        end
        vectors++;
        if (lat !== int'(e.cyc)) begin
            miscompares++;
            $display("FAIL fetch_latency: got %0d expected %0d", lat, e.cyc);
        end
        vectors++;
        if (wlog.size() != 0) begin
            miscompares++;
            $display("FAIL fetch_no_write: got %0d writes expected 0", wlog.size());
        end
    endtask

    task automatic test_store_load();
        int lat; logic [31:0] data; bit got; exp_t e;
        logic [31:0] word = 32'hDEAD_BEEF;
        logic [1:0]  ld_size [0:4] = '{SIZE_WORD, SIZE_HALF, SIZE_BYTE, 2'd3, SIZE_HALF};
        logic [31:0] ld_addr [0:4] = '{32'h10, 32'h11, 32'h13, 32'h10, 32'h12};
        logic [31:0] ld_data [0:4] = '{32'hDEAD_BEEF, 32'h0000_ADBE, 32'h0000_00DE,
                                       32'hDEAD_BEEF, 32'h0000_DEAD};
        int          ld_lat  [0:4] = '{5, 3, 2, 5, 3};
        wlog.delete();
        exp_q.push_back('{is_dm: 1'b1, data: 32'h0, cyc: 32'd5});
        dm_xfer(1'b1, SIZE_WORD, 32'h10, word, lat, data, got);
        e = exp_q.pop_front();
        vectors++;
        if (!got || lat !== int'(e.cyc) || data !== e.data) begin
            miscompares++;
            $display("FAIL store_done: got lat %0d rdata %h expected lat %0d rdata %h",
                     lat, data, e.cyc, e.data);
        end
        vectors++;
        if (wlog.size() != 4) begin
            miscompares++;
            $display("FAIL store_beats: got %0d writes expected 4", wlog.size());
        end
        for (int k = 0; k < 4 && k < wlog.size(); k++) begin
            logic [31:0] sh;
            sh = word >> (8 * k);
            vectors++;
            if (wlog[k] !== {ADDR_W'(32'h10 + k), sh[7:0]}) begin
                miscompares++;
                $display("FAIL store_beat%0d: got %h expected %h", k, wlog[k],
                         {ADDR_W'(32'h10 + k), sh[7:0]});
            end
        end
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back('{is_dm: 1'b1, data: ld_data[i], cyc: ld_lat[i]});
            dm_xfer(1'b0, ld_size[i], ld_addr[i], 32'h0, lat, data, got);
            e = exp_q.pop_front();
            vectors++;
            if (!got || data !== e.data) begin
                miscompares++;
                $display("FAIL load%0d_data: got %h expected %h", i, data, e.data);
            end
            vectors++;
            if (lat !== int'(e.cyc)) begin
                miscompares++;
                $display("FAIL load%0d_latency: got %0d expected %0d", i, lat, e.cyc);
            end
        end
        vectors++;
        if (if_rdata !== 32'h0010_0593) begin
            miscompares++;
            $display("FAIL if_rdata_kept: got %h expected 00100593", if_rdata);
        end
    endtask

    task automatic test_wrap();
        int lat; logic [31:0] data; bit got; exp_t e;
        logic [ADDR_W-1:0] exp_addr [0:3] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        poke(10'h3FE, 8'h11);
        poke(10'h3FF, 8'h22);
        alog.delete();
        exp_q.push_back('{is_dm: 1'b1, data: 32'h0513_2211, cyc: 32'd5});
        dm_xfer(1'b0, SIZE_WORD, 32'hFFFF_FFFE, 32'h0, lat, data, got);
        e = exp_q.pop_front();
        vectors++;
        if (!got || data !== e.data || lat !== int'(e.cyc)) begin
            miscompares++;
            $display("FAIL wrap_data: got %h lat %0d expected %h lat %0d", data, lat, e.data, e.cyc);
        end
        vectors++;
        if (alog.size() != 4) begin
            miscompares++;
            $display("FAIL wrap_beats: got %0d beats expected 4", alog.size());
        end
        for (int k = 0; k < 4 && k < alog.size(); k++) begin
            vectors++;
            if (alog[k] !== exp_addr[k]) begin
                miscompares++;
                $display("FAIL wrap_addr%0d: got %h expected %h", k, alog[k], exp_addr[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int c = 0;
        int dm_seen = 0;
        int if_seen = 0;
        exp_q.delete();
        for (int i = 0; i < 2; i++) begin
            c += 2; exp_q.push_back('{is_dm: 1'b1, data: 32'h0000_00DE, cyc: c});
            c += 5; exp_q.push_back('{is_dm: 1'b0, data: 32'h0000_0513, cyc: c});
        end
        dm_req = 1'b1; dm_we = 1'b0; dm_size = SIZE_BYTE; dm_addr = 32'h13;
        if_req = 1'b1; if_addr = 32'h0;
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            if (dm_done || if_done) begin
                vectors++;
                if (exp_q.size() == 0 || (dm_done && if_done)) begin
                    miscompares++;
                    $display("FAIL arb_extra_done: got dm_done=%0d if_done=%0d at cycle %0d expected none",
                             dm_done, if_done, n);
                end else begin
                    e = exp_q.pop_front();
                    if (dm_done !== e.is_dm || (dm_done ? dm_rdata : if_rdata) !== e.data
                        || n !== int'(e.cyc)) begin
                        miscompares++;
                        $display("FAIL arb_order: got dm=%0d data %h cycle %0d expected dm=%0d data %h cycle %0d",
                                 dm_done, dm_done ? dm_rdata : if_rdata, n, e.is_dm, e.data, e.cyc);
                    end
                end
                if (dm_done && ++dm_seen == 2) dm_req = 1'b0;
                if (if_done && ++if_seen == 2) if_req = 1'b0;
            end
        end
        dm_req = 1'b0; if_req = 1'b0;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL arb_all_served: got %0d outstanding expected 0", exp_q.size());
        end
        step();
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] data; bit got;
        int bad = 0;
        for (int i = 0; i < 4; i++) poke(32'h20 + i, 8'h00);
        wlog.delete();
        dm_req = 1'b1; dm_we = 1'b1; dm_size = SIZE_WORD; dm_addr = 32'h20; dm_wdata = 32'hAABB_CCDD;
        step();
        step();
        reset = 1'b1; dm_req = 1'b0;
        step();
        @(negedge clk);
        vectors++;
        if ({if_done, dm_done, if_rdata, dm_rdata, busy, mem_we, mem_addr, mem_wdata} !== '0) begin
            miscompares++;
            $display("FAIL abort_outputs: got %0h expected 0",
                     {if_done, dm_done, if_rdata, dm_rdata, busy, mem_we, mem_addr, mem_wdata});
        end
        step();
        reset = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (dm_done || mem_we || busy) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL abort_quiet: got %0d active cycles expected 0", bad);
        end
        vectors++;
        if ({mem[10'h20], mem[10'h21], mem[10'h22], mem[10'h23]} !== 32'hDDCC_0000) begin
            miscompares++;
            $display("FAIL abort_memory: got %h expected ddcc0000",
                     {mem[10'h20], mem[10'h21], mem[10'h22], mem[10'h23]});
        end
        vectors++;
        if (wlog.size() != 2) begin
            miscompares++;
            $display("FAIL abort_writes: got %0d expected 2", wlog.size());
        end
        step();
        exp_q.push_back('{is_dm: 1'b1, data: 32'h0000_00CC, cyc: 32'd2});
        dm_xfer(1'b0, SIZE_BYTE, 32'h21, 32'h0, lat, data, got);
        begin
            exp_t e;
            e = exp_q.pop_front();
            vectors++;
            if (!got || data !== e.data || lat !== int'(e.cyc)) begin
                miscompares++;
                $display("FAIL recover_load: got %h lat %0d expected %h lat %0d",
                         data, lat, e.data, e.cyc);
            end
        end
    endtask

    initial begin
        reset = 1'b1; if_req = 1'b0; if_addr = 32'h0;
        dm_req = 1'b0; dm_we = 1'b0; dm_size = 2'd0; dm_addr = 32'h0; dm_wdata = 32'h0;
        poke_en = 1'b0; poke_addr = '0; poke_data = 8'h00;
        test_reset();
        test_fetch();
        test_store_load();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single byte-wide, asynchronous-read instruction/data memory port between the IF-stage fetch requester and the MEM-stage load/store requester.
- Sequences each word, halfword or byte access as consecutive little-endian byte beats: byte at addr+0 goes to bits [7:0].
- Returns the assembled, zero-extended data with a one-cycle done pulse.
- Sits between the pipeline stages and the byte-addressable memory array. Sign extension stays in the load unit.

Parameters:
- MEM_SIZE, 1024, memory size in bytes (power of two).
- ADDR_W, $clog2(MEM_SIZE), width of the memory-side byte address.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- if_req  input  1  fetch request; held high until if_done
- if_addr  input  32  fetch byte address (always a word access)
- if_done  output  1  one-cycle pulse: if_rdata valid
- if_rdata  output  32  fetched instruction
- dm_req  input  1  data request; held high until dm_done
- dm_we  input  1  1 = store, 0 = load
- dm_size  input  2  0 = byte, 1 = half, 2 = word, 3 = reserved (treated as word)
- dm_addr  input  32  data byte address
- dm_wdata  input  32  store data; low bytes used for byte/half
- dm_done  output  1  one-cycle pulse: load data valid / store complete
- dm_rdata  output  32  load data, zero-extended
- busy  output  1  high while in BUSY
- mem_addr  output  ADDR_W  byte address to the memory
- mem_we  output  1  byte write enable
- mem_wdata  output  8  byte write data
- mem_rdata  input  8  combinational read byte at mem_addr

Behaviour:
- Reset values: if_done = 0, dm_done = 0, if_rdata = 0, dm_rdata = 0, busy = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0; state = IDLE.
- Reset mid-transfer aborts the transfer: no done pulse, no further writes, partial rdata is discarded.
- States:
  - IDLE: arbitrate.
  - BUSY: one beat per cycle; beat counter runs 0..N-1, with N = 1/2/4 for byte/half/word.
- Arbitration in IDLE:
  - dm_req has priority over if_req.
  - A requester whose done is asserted in the current cycle is masked. This prevents re-granting a request the requester is about to drop, and gives the other requester the next slot, so there is no starvation.
- On grant, latch owner, base address, N, we and wdata, then go to BUSY.
- BUSY beat k:
  - mem_addr = (base + k) modulo 2^ADDR_W, so addresses wrap at the top of memory.
  - Upper address bits beyond ADDR_W are ignored.
  - No alignment check: misaligned accesses simply cross word boundaries.
- Read beat: mem_rdata is captured into byte lane k of the assembly register. Lanes >= N read as 0.
- Write beat: mem_we = 1 and mem_wdata = wdata[8k+7:8k].
- mem_we is 0 in every other state and cycle.
- After beat N-1:
  - Return to IDLE.
  - On that edge, the owner's done is registered high for exactly one cycle.
  - The owner's rdata is updated from the assembly register (stores also update dm_rdata with 0).
  - The non-owner's rdata is unchanged.
- Latency from the first cycle req is seen high in IDLE to done high:
  - word: 5 cycles
  - half: 3 cycles
  - byte: 2 cycles
- Back-to-back: IDLE may grant the other requester in the same cycle a done is asserted, so there are zero dead cycles between transfers.
- Simultaneous if_req and dm_req: DM is served first. IF is served next, even if DM re-requests immediately after its done.
- Request inputs are sampled only in IDLE. Changing if_addr/dm_* during BUSY has no effect on the current transfer.
- busy = (state == BUSY).

Decomposition:
- Add to RISCV_PKG.vh:
  - SIZE_BYTE / SIZE_HALF / SIZE_WORD encodings
  - ARB_IDLE / ARB_BUSY state codes
  - OWNER_IF / OWNER_DM
- One natural sub-module: mem_byte_sequencer. It holds the beat counter, address increment and lane capture/select, and is driven by the arbiter FSM.

Test Plan:
- Memory preloaded with bytes 0x00..0x07 = 13 05 00 00 93 05 10 00. if_req with if_addr = 4 → if_done 5 cycles later, if_rdata = 0x00100593, mem_we never asserted.
- dm store word: dm_addr = 0x10, dm_wdata = 0xDEADBEEF, dm_size = 2 → mem_we on 4 consecutive cycles, addresses 0x10..0x13, data EF BE AD DE. A following load word returns 0xEFBEADDE? No: it returns 0xDEADBEEF.
- dm load half at 0x11 after that store (misaligned) → dm_done after 3 cycles, dm_rdata = 0x0000ADBE. Load byte at 0x13 → 0x000000DE after 2 cycles.
- if_req and dm_req raised in the same cycle with DM re-requesting continuously → order DM, IF, DM, IF. if_done is asserted exactly one cycle after the first dm_done + 4 beats, and IF is never skipped.
- Word access at address MEM_SIZE-2 (0x3FE) → mem_addr sequence 0x3FE, 0x3FF, 0x000, 0x001.
- reset asserted on beat 2 of a store word → mem_we = 0 and busy = 0 from the next cycle, no dm_done pulse, bytes 2 and 3 unwritten, all outputs at reset values.
